// File: rtl/mm_host_sequencer_pkg.sv
// Shared widths, bus field positions, FSM states and element helpers for the
// 2x2 matrix-multiplier host sequencer.
package mm_pkg;

    localparam int ELEM_W   = 2;
    localparam int C_ELEM_W = 4;

    // Operand byte layout: x00 in the MSBs down to x11 in the LSBs
    localparam int X00_LSB = 6;
    localparam int X01_LSB = 4;
    localparam int X10_LSB = 2;
    localparam int X11_LSB = 0;

    // Result byte layout: {c_hi[7:4], c_lo[3:0]}
    localparam int C_HI_LSB = 4;
    localparam int C_LO_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Saturate a sign-extended element into the tile's 2-bit range [-2,+1]
    function automatic logic signed [ELEM_W-1:0] clamp2(input logic signed [31:0] v);
        logic signed [ELEM_W-1:0] r;
        if (v > 32'sd1) begin
            r = 2'sb01;
        end else if (v < -32'sd2) begin
            r = 2'sb10;
        end else begin
            r = v[ELEM_W-1:0];
        end
        return r;
    endfunction

    function automatic logic signed [C_ELEM_W-1:0] sat4(input logic signed [7:0] v);
        logic signed [C_ELEM_W-1:0] r;
        if (v > 8'sd7) begin
            r = 4'sb0111;
        end else if (v < -8'sd8) begin
            r = 4'sb1000;
        end else begin
            r = v[C_ELEM_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mm_host_sequencer_if.sv
// Host-side operand/result handshake bundle for mm_host_sequencer.
interface mm_host_sequencer_if #(
    parameter int IN_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*IN_W-1:0]     in_a;
    logic [4*IN_W-1:0]     in_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [15:0]           out_c;
    logic                  out_mismatch;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_c, out_mismatch
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_c, out_mismatch
    );
endinterface

// File: rtl/mm_host_sequencer_golden.sv
// Combinational reference 2x2 signed multiply of packed 2-bit operands,
// each result element saturated to 4-bit signed.
module mm_golden_2x2
    import mm_pkg::*;
(
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] c_o
);

    logic signed [ELEM_W-1:0] a_s   [4];
    logic signed [ELEM_W-1:0] b_s   [4];
    logic signed [7:0]        acc_s [4];

    // Unpack, multiply-accumulate and saturate; element index is row*2+col
    always_comb begin
        c_o = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            a_s[i]   = a_i[(3-i)*ELEM_W +: ELEM_W];
            b_s[i]   = b_i[(3-i)*ELEM_W +: ELEM_W];
            acc_s[i] = 8'sd0;
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                acc_s[r*2+c] = 8'(a_s[r*2])   * 8'(b_s[c])
                             + 8'(a_s[r*2+1]) * 8'(b_s[2+c]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            c_o[(3-i)*C_ELEM_W +: C_ELEM_W] = sat4(acc_s[i]);
        end
    end

endmodule

// File: rtl/mm_host_sequencer.sv
// Host driver/reader for the 2x2 signed matrix tile: clamp+pack operands, hold mm_ena for
// the tile latency, capture the result. Optional golden self-check under MM_SELFCHECK_EN.
module mm_host_sequencer
    import mm_pkg::*;
#(
    parameter int IN_W       = 4,
    parameter int MM_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mm_host_sequencer_if.slave   host,
    output logic                 mm_ena,
    output logic [7:0]           mm_ui_in,
    output logic [7:0]           mm_uio_in,
    input  logic [7:0]           mm_uo_out,
    input  logic [7:0]           mm_uio_out
);

    localparam int CNT_W = (MM_LATENCY > 0) ? $clog2(MM_LATENCY + 1) : 1;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_ready_q;
    logic               mm_ena_q;
    logic [7:0]         mm_ui_in_q;
    logic [7:0]         mm_uio_in_q;
    logic               out_valid_q;
    logic [15:0]        out_c_q;
    logic               out_mismatch_q;

    logic [7:0]         pack_a_d;
    logic [7:0]         pack_b_d;
    logic               mismatch_d;

    // Clamp each wide element to 2 bits and pack into the tile byte layout
    always_comb begin
        pack_a_d = 8'h00;
        pack_b_d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            pack_a_d[(3-i)*ELEM_W +: ELEM_W] = clamp2(32'(signed'(host.in_a[(3-i)*IN_W +: IN_W])));
            pack_b_d[(3-i)*ELEM_W +: ELEM_W] = clamp2(32'(signed'(host.in_b[(3-i)*IN_W +: IN_W])));
        end
    end

`ifdef MM_SELFCHECK_EN
    logic [15:0] golden_c_s;

    // Golden works from the registered (already clamped) operands the tile actually sees
    mm_golden_2x2 u_golden (
        .a_i (mm_ui_in_q),
        .b_i (mm_uio_in_q),
        .c_o (golden_c_s)
    );

    assign mismatch_d = (golden_c_s != {mm_uo_out, mm_uio_out});
`else
    assign mismatch_d = 1'b0;
`endif

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= {CNT_W{1'b0}};
            in_ready_q     <= 1'b1;
            mm_ena_q       <= 1'b0;
            mm_ui_in_q     <= 8'h00;
            mm_uio_in_q    <= 8'h00;
            out_valid_q    <= 1'b0;
            out_c_q        <= 16'h0000;
            out_mismatch_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (host.in_valid && in_ready_q) begin
                        mm_ui_in_q  <= pack_a_d;
                        mm_uio_in_q <= pack_b_d;
                        cnt_q       <= {CNT_W{1'b0}};
                        mm_ena_q    <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= DRIVE;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                DRIVE: begin
                    if (cnt_q == CNT_W'(MM_LATENCY)) begin
                        out_c_q        <= {mm_uo_out, mm_uio_out};
                        out_mismatch_q <= mismatch_d;
                        mm_ena_q       <= 1'b0;
                        out_valid_q    <= 1'b1;
                        state_q        <= RESP;
                    end else begin
                        cnt_q          <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    // Return to IDLE only; the next accept is at least one cycle later
                    if (host.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= RESP;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= {CNT_W{1'b0}};
                    in_ready_q  <= 1'b1;
                    mm_ena_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign host.in_ready     = in_ready_q;
    assign host.out_valid    = out_valid_q;
    assign host.out_c        = out_c_q;
    assign host.out_mismatch = out_mismatch_q;
    assign mm_ena            = mm_ena_q;
    assign mm_ui_in          = mm_ui_in_q;
    assign mm_uio_in         = mm_uio_in_q;

endmodule

// File: tb/tb_mm_host_sequencer.sv
// Directed self-checking bench for mm_host_sequencer (latencies 2, 0 and 3).
module tb_mm_host_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0] uo;
    logic [7:0] uio;

    mm_host_sequencer_if #(.IN_W(4)) h2 ();
    mm_host_sequencer_if #(.IN_W(4)) h0 ();
    mm_host_sequencer_if #(.IN_W(4)) h3 ();

    logic       ena2, ena0, ena3;
    logic [7:0] ui2, uib2, ui0, uib0, ui3, uib3;

    mm_host_sequencer #(.IN_W(4), .MM_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .host(h2.slave), .mm_ena(ena2), .mm_ui_in(ui2),
        .mm_uio_in(uib2), .mm_uo_out(uo), .mm_uio_out(uio));
    mm_host_sequencer #(.IN_W(4), .MM_LATENCY(0)) dut_l0 (
        .clk(clk), .rst(rst), .host(h0.slave), .mm_ena(ena0), .mm_ui_in(ui0),
        .mm_uio_in(uib0), .mm_uo_out(uo), .mm_uio_out(uio));
    mm_host_sequencer #(.IN_W(4), .MM_LATENCY(3)) dut_l3 (
        .clk(clk), .rst(rst), .host(h3.slave), .mm_ena(ena3), .mm_ui_in(ui3),
        .mm_uio_in(uib3), .mm_uo_out(uo), .mm_uio_out(uio));

`ifdef MM_SELFCHECK_EN
    localparam logic EXP_T6_MM = 1'b1;
`else
    localparam logic EXP_T6_MM = 1'b0;
`endif

    int errs   = 0;
    int checks = 0;
    int ena_cnt;
    int lat;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        uo = 8'h00; uio = 8'h00;
        h2.in_valid = 1'b0; h2.in_a = 16'h0000; h2.in_b = 16'h0000; h2.out_ready = 1'b0;
        h0.in_valid = 1'b0; h0.in_a = 16'h0000; h0.in_b = 16'h0000; h0.out_ready = 1'b1;
        h3.in_valid = 1'b0; h3.in_a = 16'h0000; h3.in_b = 16'h0000; h3.out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  16'(h2.in_ready),     16'd1);
        chk("rst_mm_ena",    16'(ena2),            16'd0);
        chk("rst_ui_in",     16'(ui2),             16'h0000);
        chk("rst_uio_in",    16'(uib2),            16'h0000);
        chk("rst_out_valid", 16'(h2.out_valid),    16'd0);
        chk("rst_out_c",     h2.out_c,             16'h0000);
        chk("rst_mismatch",  16'(h2.out_mismatch), 16'd0);

        // Test 1: A=[[1,-1],[-2,1]], B=I
        uo = 8'h1F; uio = 8'hE1;
        h2.in_a = 16'h1FE1; h2.in_b = 16'h1001; h2.in_valid = 1'b1;
        tick();
        h2.in_valid = 1'b0;
        chk("t1_ena_on",   16'(ena2),        16'd1);
        chk("t1_ui_in",    16'(ui2),         16'h0079);
        chk("t1_uio_in",   16'(uib2),        16'h0041);
        chk("t1_in_ready", 16'(h2.in_ready), 16'd0);
        ena_cnt = 1; lat = 0;
        for (int k = 1; k < 20 && !h2.out_valid; k++) begin
            tick();
            lat = k;
            if (ena2) ena_cnt++;
        end
        chk("t1_ena_cycles", 16'(ena_cnt),         16'd3);
        chk("t1_valid_lat",  16'(lat),             16'd3);
        chk("t1_out_c",      h2.out_c,             16'h1FE1);
        chk("t1_mismatch",   16'(h2.out_mismatch), 16'd0);

        // Test 4: backpressure, with a new operand pair presented but not yet accepted
        h2.in_a = 16'h5900; h2.in_b = 16'h0000; h2.in_valid = 1'b1;
        uo = 8'h00; uio = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_out_valid", 16'(h2.out_valid), 16'd1);
            chk("bp_out_c",     h2.out_c,          16'h1FE1);
            chk("bp_in_ready",  16'(h2.in_ready),  16'd0);
            chk("bp_ui_held",   16'(ui2),          16'h0079);
        end
        h2.out_ready = 1'b1;
        tick();
        chk("bp_rel_valid", 16'(h2.out_valid), 16'd0);
        chk("bp_rel_ready", 16'(h2.in_ready),  16'd1);
        chk("bp_ui_kept",   16'(ui2),          16'h0079);
        chk("bp_ena_off",   16'(ena2),         16'd0);

        // Test 2: clamp a00=+5, a01=-7, accepted one cycle after the handshake
        tick();
        h2.in_valid = 1'b0;
        chk("t2_ui_in",  16'(ui2),  16'h0060);
        chk("t2_uio_in", 16'(uib2), 16'h0000);
        for (int k = 0; k < 20 && !h2.out_valid; k++) tick();
        chk("t2_valid", 16'(h2.out_valid),    16'd1);
        chk("t2_out_c", h2.out_c,             16'h0000);
        chk("t2_mm",    16'(h2.out_mismatch), 16'd0);
        tick();
        chk("t2_done", 16'(h2.in_ready), 16'd1);

        // Test 6: tile corrupts c11
        uo = 8'h1F; uio = 8'hE0;
        h2.in_a = 16'h1FE1; h2.in_b = 16'h1001; h2.in_valid = 1'b1;
        tick();
        h2.in_valid = 1'b0;
        for (int k = 0; k < 20 && !h2.out_valid; k++) tick();
        chk("t6_valid",    16'(h2.out_valid),    16'd1);
        chk("t6_out_c",    h2.out_c,             16'h1FE0);
        chk("t6_mismatch", 16'(h2.out_mismatch), 16'(EXP_T6_MM));
        tick();

        // Test 5: reset while in DRIVE with cnt=1
        uio = 8'hE1;
        h2.in_valid = 1'b1;
        tick();
        h2.in_valid = 1'b0;
        tick();
        chk("t5_ena_pre", 16'(ena2), 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ena_off",  16'(ena2),        16'd0);
        chk("t5_in_ready", 16'(h2.in_ready), 16'd1);
        chk("t5_out_c",    h2.out_c,         16'h0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_no_valid", 16'(h2.out_valid), 16'd0);
        end

        // Test 3: latency 0 and 3 instances, accepted on the same edge
        h0.in_a = 16'h1FE1; h0.in_b = 16'h1001; h0.in_valid = 1'b1;
        h3.in_a = 16'h1FE1; h3.in_b = 16'h1001; h3.in_valid = 1'b1;
        tick();
        h0.in_valid = 1'b0; h3.in_valid = 1'b0;
        chk("t3_l0_ena_on", 16'(ena0), 16'd1);
        chk("t3_l3_ena_on", 16'(ena3), 16'd1);
        ena_cnt = 1; lat = 0;
        for (int k = 1; k < 20 && !h0.out_valid; k++) begin
            tick();
            lat = k;
            if (ena0) ena_cnt++;
        end
        chk("t3_l0_ena_cycles", 16'(ena_cnt), 16'd1);
        chk("t3_l0_valid_lat",  16'(lat),     16'd1);
        chk("t3_l0_out_c",      h0.out_c,     16'h1FE1);
        // dut_l3 is one cycle past accept here and its mm_ena has been high twice
        ena_cnt = 2;
        for (int k = 2; k < 20 && !h3.out_valid; k++) begin
            tick();
            lat = k;
            if (ena3) ena_cnt++;
        end
        chk("t3_l3_ena_cycles", 16'(ena_cnt), 16'd4);
        chk("t3_l3_valid_lat",  16'(lat),     16'd4);
        chk("t3_l3_out_c",      h3.out_c,     16'h1FE1);
        tick();
        chk("t3_l3_idle", 16'(h3.in_ready), 16'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
